// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality checks used at acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  // Stores only know B/H/W; loads additionally accept the unsigned variants.
  function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
    if (write)
      return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    else
      return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
               funct3 == F3_BU || funct3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
    case (funct3)
      F3_H, F3_HU: return byte_off[0];
      F3_W:        return byte_off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane handling: extracts and extends load data from a raw
// word, and merges sub-word store data into a word read back from memory.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] raw_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    load_value  = raw_word;
    merged_word = store_data;
    byte_sel    = raw_word[{byte_off, 3'b000} +: 8];
    half_sel    = byte_off[1] ? raw_word[31:16] : raw_word[15:0];

    case (funct3)
      F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_value = {24'd0, byte_sel};
      F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_value = {16'd0, half_sel};
      default: load_value = raw_word;
    endcase

    case (funct3)
      F3_B: begin
        merged_word = raw_word;
        merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      end
      F3_H: begin
        merged_word = raw_word;
        if (byte_off[1]) merged_word[31:16] = store_data[15:0];
        else             merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and a word-wide
// data memory; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state;
  logic [2:0]  funct3_q;
  logic [1:0]  byte_off_q;
  logic [31:0] wdata_q;
  logic        req_err;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  // The range check runs before any access, so the word index can never wrap.
  assign req_err = funct3_illegal(req_write, req_funct3) ||
                   misaligned(req_funct3, req_addr[1:0]) ||
                   (req_addr >= 32'(MEMORY_SIZE));

  lsu_data_align u_align (
    .funct3      (funct3_q),
    .byte_off    (byte_off_q),
    .raw_word    (mem_read_data),
    .store_data  (wdata_q),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= 32'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
      funct3_q       <= 3'd0;
      byte_off_q     <= 2'd0;
      wdata_q        <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_q    <= req_funct3;
            byte_off_q  <= req_addr[1:0];
            wdata_q     <= req_wdata;
            mem_address <= {2'b00, req_addr[31:2]};
            resp_rdata  <= 32'd0;
            resp_error  <= req_err;
            resp_valid  <= req_err;
            req_ready   <= 1'b0;
            if (req_err) begin
              state <= ST_RESP;
            end else if (!req_write) begin
              state    <= ST_LOAD;
              mem_read <= 1'b1;
            end else if (req_funct3 == F3_W) begin
              state          <= ST_WRITE;
              mem_write      <= 1'b1;
              mem_write_data <= req_wdata;
            end else begin
              state    <= ST_RMW_READ;
              mem_read <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          mem_read   <= 1'b0;
          resp_rdata <= load_value;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RMW_READ: begin
          mem_read       <= 1'b0;
          mem_write      <= 1'b1;
          mem_write_data <= merged_word;
          state          <= ST_WRITE;
        end
        ST_WRITE: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written handshake and
// reset sequences, then random requests checked against a byte-array model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEMORY_SIZE(4096)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Word-wide data memory with combinational read, one write per clock.
  logic [31:0] mem [0:1023];
  assign mem_read_data = mem[mem_address[9:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[9:0]] <= mem_write_data;

  // Reference model state: plain little-endian byte array.
  logic [7:0] ref_bytes [0:4095];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int nrd, output int nwr);
    int size;
    logic illegal;
    logic [31:0] v;
    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    er  = illegal || (addr % 32'(size) != 0) || (addr >= 32'd4096);
    rd  = 32'd0;
    nrd = 0;
    nwr = 0;
    if (er) begin
      lat = 1;
    end else if (wr) begin
      for (int i = 0; i < size; i++) ref_bytes[int'(addr) + i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8*i));
      if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd  = v;
      lat = 2;
      nrd = 1;
    end
  endtask

  // Issue one request in the first IDLE cycle and observe it up to its response.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                        output int lat, output int nrd, output int nwr, output logic [31:0] wseen);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; nrd = 0; nwr = 0; rdata = 32'd0; err = 1'b0; wseen = 32'd0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check("single_strobe", mem_read & mem_write, 0);
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        wseen = mem_write_data;
      end
      if (resp_valid) begin
        lat = n; rdata = resp_rdata; err = resp_error;
        break;
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic        chk_wd;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata, wseen, e_rd, e1, e2;
    logic        err, e_er;
    int          lat, nrd, nwr, e_lat, e_nrd, e_nwr;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    int          r;

    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'd0;
    mem[3] = 32'h0000_0217;
    ref_bytes[12] = 8'h17;
    ref_bytes[13] = 8'h02;

    req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_resp_error", resp_error, 0);
    check("reset_resp_rdata", resp_rdata, 0);
    check("reset_mem_read", mem_read, 0);
    check("reset_mem_write", mem_write, 0);
    check("reset_mem_address", mem_address, 0);
    check("reset_mem_write_data", mem_write_data, 0);
    reset = 1'b0;

    vecs[0]  = '{1'b0, F3_B,   32'h0C,   32'h0,        32'h0000_0017, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, F3_H,   32'h0C,   32'h0,        32'h0000_0217, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, F3_W,   32'h0C,   32'h0,        32'h0000_0217, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, F3_W,   32'h10,   32'h80FF7F01, 32'h0,         1'b0, 2, 0, 1, 1'b1, 32'h80FF7F01};
    vecs[4]  = '{1'b0, F3_B,   32'h11,   32'h0,        32'h0000_007F, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, F3_B,   32'h12,   32'h0,        32'hFFFF_FFFF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, F3_BU,  32'h12,   32'h0,        32'h0000_00FF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, F3_H,   32'h12,   32'h0,        32'hFFFF_80FF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, F3_HU,  32'h12,   32'h0,        32'h0000_80FF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, F3_B,   32'h13,   32'h123456AA, 32'h0,         1'b0, 3, 1, 1, 1'b1, 32'hAAFF7F01};
    vecs[10] = '{1'b0, F3_W,   32'h10,   32'h0,        32'hAAFF_7F01, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, F3_H,   32'h10,   32'h0000BEEF, 32'h0,         1'b0, 3, 1, 1, 1'b1, 32'hAAFFBEEF};
    vecs[12] = '{1'b0, F3_W,   32'h10,   32'h0,        32'hAAFF_BEEF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, F3_H,   32'h01,   32'h0,        32'h0,         1'b1, 1, 0, 0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, F3_W,   32'h1000, 32'h0,        32'h0,         1'b1, 1, 0, 0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 3'b011, 32'h0,    32'h0,        32'h0,         1'b1, 1, 0, 0, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 3'b100, 32'h0,    32'h12345678, 32'h0,         1'b1, 1, 0, 0, 1'b0, 32'h0};

    for (int i = 0; i < 17; i++) begin
      model(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, e_rd, e_er, e_lat, e_nrd, e_nwr);
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, rdata, err, lat, nrd, nwr, wseen);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
      check($sformatf("vec%0d_error", i), err, vecs[i].err);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_read_cycles", i), nrd, vecs[i].nrd);
      check($sformatf("vec%0d_write_cycles", i), nwr, vecs[i].nwr);
      if (vecs[i].chk_wd) check($sformatf("vec%0d_write_data", i), wseen, vecs[i].exp_wd);
    end

    // Handshake: req_valid held high while busy, address changing underneath.
    model(1'b0, F3_W, 32'h10, 32'h0, e1, e_er, e_lat, e_nrd, e_nwr);
    model(1'b0, F3_W, 32'h0C, 32'h0, e2, e_er, e_lat, e_nrd, e_nwr);
    @(negedge clk);
    check("hs_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    check("hs_busy_ready_c1", req_ready, 0);
    check("hs_mem_read_c1", mem_read, 1);
    check("hs_mem_address_c1", mem_address, 32'd4);
    req_addr = 32'h14;
    @(negedge clk);
    check("hs_resp_valid_c2", resp_valid, 1);
    check("hs_rdata_first", resp_rdata, e1);
    check("hs_busy_ready_c2", req_ready, 0);
    req_addr = 32'h0C;
    @(negedge clk);
    check("hs_ready_c3", req_ready, 1);
    check("hs_resp_low_c3", resp_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("hs_b2b_ready_c4", req_ready, 0);
    check("hs_b2b_mem_read", mem_read, 1);
    check("hs_b2b_mem_address", mem_address, 32'd3);
    @(negedge clk);
    check("hs_b2b_resp_valid", resp_valid, 1);
    check("hs_b2b_rdata", resp_rdata, e2);

    // Reset in the middle of an RMW: the pending write must never be issued.
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_rmw_read_active", mem_read, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_resp_valid", resp_valid, 0);
    check("rst_mid_resp_error", resp_error, 0);
    check("rst_mid_resp_rdata", resp_rdata, 0);
    check("rst_mid_mem_read", mem_read, 0);
    check("rst_mid_mem_write", mem_write, 0);
    check("rst_mid_mem_address", mem_address, 0);
    check("rst_mid_mem_write_data", mem_write_data, 0);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("rst_after_no_write", mem_write, 0);
      check("rst_after_no_resp", resp_valid, 0);
    end
    check("rst_word8_untouched", mem[8], 32'd0);

    // Random requests against the byte-array model.
    for (int k = 0; k < 300; k++) begin
      wr = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'd4092 + 32'($urandom_range(0, 7));
      else             addr = 32'($urandom_range(0, 127));
      wd = $urandom;
      model(wr, f3, addr, wd, e_rd, e_er, e_lat, e_nrd, e_nwr);
      do_req(wr, f3, addr, wd, rdata, err, lat, nrd, nwr, wseen);
      check($sformatf("rnd%0d_rdata", k), rdata, e_rd);
      check($sformatf("rnd%0d_error", k), err, e_er);
      check($sformatf("rnd%0d_latency", k), lat, e_lat);
      check($sformatf("rnd%0d_read_cycles", k), nrd, e_nrd);
      check($sformatf("rnd%0d_write_cycles", k), nwr, e_nwr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
